// File: rtl/instr_encoder_loader.sv
// Program loader: packs symbolic instructions into MIPS-lite words and writes
// them to consecutive instruction-memory addresses.
module instr_encoder_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_func,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err_illegal
);
    // Handshake: a transfer happens at a rising edge where in_valid & in_ready.
    // The source holds its fields stable while in_valid is high and in_ready low.
    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [3:0] {
        OP_RTYPE  = 4'd0,
        OP_LW     = 4'd1,
        OP_SW     = 4'd2,
        OP_BEQ    = 4'd3,
        OP_NORI   = 4'd4,
        OP_BLEZAL = 4'd5,
        OP_JALPC  = 4'd6,
        OP_BALN   = 4'd7,
        OP_JMXOR  = 4'd8,
        OP_BRV    = 4'd9
    } op_e;

    logic [ADDR_W-1:0] ptr;
    logic [31:0]       word;
    logic              legal;
    logic              accept;

    assign full     = (count == FULL_COUNT);
    assign in_ready = ~full & ~clear;
    assign accept   = in_valid & in_ready;

    always_comb begin
        word  = 32'd0;
        legal = 1'b1;
        case (op_e'(in_op))
            OP_RTYPE:  word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, in_func};
            OP_JMXOR:  word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100001};
            OP_BRV:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b010100};
            OP_LW:     word = {6'b100011, in_rs, in_rt, in_imm};
            OP_SW:     word = {6'b101011, in_rs, in_rt, in_imm};
            OP_BEQ:    word = {6'b000100, in_rs, in_rt, in_imm};
            OP_NORI:   word = {6'b001111, in_rs, in_rt, in_imm};
            OP_BLEZAL: word = {6'b100100, in_rs, in_rt, in_imm};
            OP_JALPC:  word = {6'b011111, in_target};
            OP_BALN:   word = {6'b011011, in_target};
            default:   legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= '0;
            count       <= '0;
            err_illegal <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 32'd0;
        end else if (clear) begin
            ptr         <= '0;
            count       <= '0;
            err_illegal <= 1'b0;
            mem_we      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                if (legal) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= ptr;
                    mem_wdata <= word;
                    count     <= count + 1'b1;
                    // The pointer parks on the last address instead of wrapping.
                    if (ptr != {ADDR_W{1'b1}}) ptr <= ptr + 1'b1;
                end else begin
                    err_illegal <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: spec-level model checked every
// cycle, plus literal expectations for the hand-encoded instruction words.
module tb_instr_encoder_loader;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_op = '0;
    logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0;
    logic [5:0]    in_func = '0;
    logic [15:0]   in_imm = '0;
    logic [25:0]   in_target = '0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   count;
    logic          full;
    logic          err_illegal;

    int checks = 0;
    int failures = 0;

    instr_encoder_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_func(in_func),
        .in_imm(in_imm), .in_target(in_target),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .full(full), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Encoding table written straight from the instruction formats.
    function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rs, rt, rd,
                                        input logic [5:0] fn, input logic [15:0] imm,
                                        input logic [25:0] tg);
        logic [31:0] r_base, i_rs_rt;
        r_base  = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11);
        i_rs_rt = (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
        case (op)
            4'd0: return r_base | 32'(fn);
            4'd1: return (32'd35 << 26) | i_rs_rt;
            4'd2: return (32'd43 << 26) | i_rs_rt;
            4'd3: return (32'd4  << 26) | i_rs_rt;
            4'd4: return (32'd15 << 26) | i_rs_rt;
            4'd5: return (32'd36 << 26) | i_rs_rt;
            4'd6: return (32'd31 << 26) | 32'(tg);
            4'd7: return (32'd27 << 26) | 32'(tg);
            4'd8: return r_base | 32'd33;
            4'd9: return r_base | 32'd20;
            default: return 32'd0;
        endcase
    endfunction

    // Model: words written so far equals the next address while not full.
    bit   m_on = 0;
    int   e_cnt = 0;
    bit   e_err = 0, e_we = 0;
    int   e_addr = 0;
    logic [31:0] e_data = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_on = 1; e_cnt = 0; e_err = 0; e_we = 0; e_addr = 0; e_data = 0;
        end else if (clear) begin
            e_cnt = 0; e_err = 0; e_we = 0;
        end else begin
            e_we = 0;
            if (in_valid && e_cnt < DEPTH) begin
                if (in_op > 4'd9) e_err = 1;
                else begin
                    e_we = 1; e_addr = e_cnt;
                    e_data = enc(in_op, in_rs, in_rt, in_rd, in_func, in_imm, in_target);
                    e_cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("m_mem_we", 64'(mem_we), 64'(e_we));
            chk("m_count", 64'(count), 64'(e_cnt));
            chk("m_full", 64'(full), 64'(e_cnt == DEPTH));
            chk("m_err", 64'(err_illegal), 64'(e_err));
            chk("m_in_ready", 64'(in_ready), 64'(e_cnt < DEPTH && !clear));
            if (e_we) begin
                chk("m_mem_addr", 64'(mem_addr), 64'(e_addr));
                chk("m_mem_wdata", 64'(mem_wdata), 64'(e_data));
            end
        end
    end

    logic [AW+31:0] got_q[$];
    always @(negedge clk) if (m_on && mem_we === 1'b1) got_q.push_back({mem_addr, mem_wdata});

    task automatic expect_wr(input string name, input int addr, input logic [31:0] data);
        logic [AW+31:0] w;
        if (got_q.size() == 0) begin
            chk({name, "_present"}, 64'd0, 64'd1);
        end else begin
            w = got_q.pop_front();
            chk({name, "_addr"}, 64'(w[AW+31:32]), 64'(addr));
            chk({name, "_data"}, 64'(w[31:0]), 64'(data));
        end
    endtask

    task automatic offer(input logic [3:0] op, input logic [4:0] rs, rt, rd,
                         input logic [5:0] fn, input logic [15:0] imm,
                         input logic [25:0] tg, input int bound, output bit acc);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_func = fn; in_imm = imm; in_target = tg; in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < bound && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #2;
                acc = 1;
            end
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rs, rt, rd,
                        input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tg);
        bit acc;
        offer(op, rs, rt, rd, fn, imm, tg, 20, acc);
        chk("accepted", 64'(acc), 64'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #2;
        clear = 1'b0;
    endtask

    initial begin
        bit acc;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_err", 64'(err_illegal), 64'd0);
        @(posedge clk); #2;

        // Single LW, one-cycle latency.
        send(4'd1, 5'd2, 5'd5, 5'd0, 6'd0, 16'h0010, 26'd0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lw_we", 64'(mem_we), 64'd1);
        chk("lw_addr", 64'(mem_addr), 64'd0);
        chk("lw_data", 64'(mem_wdata), 64'h8C450010);
        chk("lw_count", 64'(count), 64'd1);
        idle(1);
        got_q.delete();
        pulse_clear();

        // Back-to-back mixed formats.
        send(4'd4, 5'd1, 5'd3, 5'd0, 6'd0, 16'hFFFF, 26'd0);
        send(4'd8, 5'd4, 5'd0, 5'd31, 6'd0, 16'd0, 26'd0);
        send(4'd9, 5'd7, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
        send(4'd7, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000100);
        idle(2);
        expect_wr("nori", 0, 32'h3C23FFFF);
        expect_wr("jmxor", 1, 32'h0080F821);
        expect_wr("brv", 2, 32'h00E00014);
        expect_wr("baln", 3, 32'h6C000100);
        pulse_clear();

        // Fill to capacity; the fifth offer must stall.
        for (int i = 0; i < 4; i++) send(4'd1, 5'(i), 5'd1, 5'd0, 6'd0, 16'(i), 26'd0);
        offer(4'd1, 5'd9, 5'd9, 5'd0, 6'd0, 16'd9, 26'd0, 6, acc);
        chk("fifth_rejected", 64'(acc), 64'd0);
        in_valid = 1'b0;
        chk("full_count", 64'(count), 64'd4);
        chk("full_flag", 64'(full), 64'd1);
        chk("full_ready", 64'(in_ready), 64'd0);
        idle(1);
        chk("full_writes", 64'(got_q.size()), 64'd4);
        got_q.delete();
        pulse_clear();

        // Illegal op sets the sticky flag without writing.
        send(4'd1, 5'd1, 5'd1, 5'd0, 6'd0, 16'd1, 26'd0);
        send(4'd12, 5'd3, 5'd3, 5'd3, 6'd0, 16'd0, 26'd0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("ill_we", 64'(mem_we), 64'd0);
        chk("ill_count", 64'(count), 64'd1);
        chk("ill_err", 64'(err_illegal), 64'd1);
        @(posedge clk); #2;
        send(4'd2, 5'd0, 5'd1, 5'd0, 6'd0, 16'd4, 26'd0);
        send(4'd0, 5'd1, 5'd2, 5'd3, 6'h2A, 16'd0, 26'd0);
        idle(2);
        expect_wr("pre_ill", 1 - 1, enc(4'd1, 5'd1, 5'd1, 5'd0, 6'd0, 16'd1, 26'd0));
        expect_wr("sw", 1, 32'hAC010004);
        expect_wr("rtype", 2, 32'h0022182A);
        pulse_clear();
        @(negedge clk);
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_err", 64'(err_illegal), 64'd0);
        chk("clr_full", 64'(full), 64'd0);
        @(posedge clk); #2;
        send(4'd3, 5'd5, 5'd6, 5'd0, 6'd0, 16'h8000, 26'd0);
        send(4'd5, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0003, 26'd0);
        send(4'd6, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h3FFFFFF);
        idle(2);
        expect_wr("beq", 0, 32'h10A68000);
        expect_wr("blezal", 1, 32'h90400003);
        expect_wr("jalpc", 2, 32'h7FFFFFFF);
        pulse_clear();

        // Reset in the cycle after an accept drops the pending write.
        send(4'd1, 5'd2, 5'd5, 5'd0, 6'd0, 16'h0010, 26'd0);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_we", 64'(mem_we), 64'd0);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_addr", 64'(mem_addr), 64'd0);
        chk("mid_rst_wdata", 64'(mem_wdata), 64'd0);
        chk("mid_rst_err", 64'(err_illegal), 64'd0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the control decoder. It takes symbolic instructions (op class plus fields) over a valid/ready handshake.
- It packs each one into a 32-bit MIPS-lite word using the opcode and func values the decoder recognises.
- It writes the words one after another into the instruction memory.
- It is used as the program loader and the stimulus generator for the single-cycle datapath.

Parameters:
- ADDR_W, 8, width of the instruction-memory word address; capacity DEPTH = 2**ADDR_W words.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous restart: write pointer, count and error flag go to 0.
- in_valid  input  1  an instruction is offered.
- in_ready  output  1  loader can accept; in_ready = ~full & ~clear.
- in_op  input  4  0=RTYPE, 1=LW, 2=SW, 3=BEQ, 4=NORI, 5=BLEZAL, 6=JALPC, 7=BALN, 8=JMXOR, 9=BRV; 10-15 illegal.
- in_rs, in_rt, in_rd  input  5 each  register fields.
- in_func  input  6  func field, used only by RTYPE.
- in_imm  input  16  immediate, I-format.
- in_target  input  26  jump target, J-format.
- mem_we  output  1  instruction-memory write strobe, one cycle.
- mem_addr  output  ADDR_W  word address.
- mem_wdata  output  32  encoded instruction.
- count  output  ADDR_W+1  number of words written or pending.
- full  output  1  count == DEPTH.
- err_illegal  output  1  sticky: an illegal op was accepted.

Behaviour:
- Accept = in_valid & in_ready at a rising edge.
- Precedence: reset > clear > accept.
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, err_illegal=0, internal write pointer=0.
- Latency is one cycle. A legal op accepted at edge N produces mem_we=1, mem_addr=old pointer and mem_wdata=encoded word during the cycle after edge N.
  - mem_we is low in every other cycle.
  - All mem_* outputs are registered.
- On a legal accept, the pointer and count each increment by 1 at the same edge.
- Back-to-back accepts produce back-to-back writes at consecutive addresses. No bubbles.
- Encoding, all fields concatenated MSB to LSB:
  - RTYPE: {000000, rs, rt, rd, 00000, in_func}.
  - JMXOR: {000000, rs, rt, rd, 00000, 100001}.
  - BRV: {000000, rs, rt, rd, 00000, 010100}.
  - LW: {100011, rs, rt, imm}.
  - SW: {101011, rs, rt, imm}.
  - BEQ: {000100, rs, rt, imm}.
  - NORI: {001111, rs, rt, imm}.
  - BLEZAL: {100100, rs, rt, imm}.
  - JALPC: {011111, target}.
  - BALN: {011011, target}.
  - Unused input fields are ignored.
- Illegal op (10-15):
  - Accepted (handshake completes).
  - No write; pointer and count are unchanged.
  - err_illegal is set at that edge and held until reset or clear.
- Full:
  - The DEPTH-th legal accept makes count=DEPTH and full=1 at the same edge; in_ready drops immediately.
  - That last write still appears on mem_* in the following cycle.
  - There is no wrap-around. The pointer stays at DEPTH-1 once full; no write occurs at address 0.
- Clear:
  - Affects only state after the edge at which it is sampled.
  - A write already presented on mem_* in the clear cycle completes.
  - At the clear edge: count=0, full=0, err_illegal=0, pointer=0, mem_we=0.
  - Because in_ready is low while clear is high, no accept can coincide with clear.
- Reset mid-stream: all state returns to reset values at the next edge. A pending write is dropped; mem_we is 0 in the cycle after reset.
- in_valid with in_ready low: no state change. The source must hold its fields.

Test Plan:
- Encode LW rs=2, rt=5, imm=0x0010 from reset → next cycle mem_we=1, mem_addr=0, mem_wdata=0x8C450010; count=1.
- Back-to-back NORI rs=1, rt=3, imm=0xFFFF; JMXOR rs=4, rt=0, rd=31; BRV rs=7; BALN target=0x0000100 → consecutive writes at addr 0..3 of 0x3C23FFFF, 0x0080F821, 0x00E00014, 0x6C000100; mem_we high for 4 consecutive cycles.
- ADDR_W=2, offer 5 LWs continuously → 4 writes at addr 0..3; full=1 and in_ready=0 right after the 4th accept; 5th never accepted; count=4.
- in_op=12 accepted → no mem_we, count unchanged, err_illegal=1; next legal SW rs=0, rt=1, imm=4 writes 0xAC010004 at the unchanged address.
- After 3 writes plus err_illegal set, pulse clear → count=0, err_illegal=0, full=0; next legal op writes addr 0.
- Assert reset in the cycle after an accept → mem_we=0 the next cycle, all outputs at reset values.
